serdes_tx_scheduler: RTL and testbench
======================================

Name: serdes_tx_scheduler

Overview:
- Arbitrates NUM_CH AXI-Stream requesters onto the single 8-bit lane that feeds the 8b/10b encoder.
- Frames each grant as: SOF K-char, channel-ID byte, up to MAX_BURST words sent byte-serial LSB-first, EOF K-char.
- Fills all gaps between frames with K28.5 commas, which the receive side uses for alignment.
- Sits on the transmit side, between the per-channel AXIS sources and the encoder.

Parameters:
- LOGIC_SIZE, 32: AXIS word width in bits; must be a multiple of 8.
- NUM_CH, 4: number of requesting channels, 2..16.
- MAX_BURST, 4: maximum words per frame, at least 1.
- IDLE_MIN, 2: minimum number of consumed commas between frames, at least 1.

Ports:
- m_axis_aclk, in, 1: single clock.
- m_axis_reset_n, in, 1: reset; asynchronous, active-low.
- s_ch_tdata, in, NUM_CH*LOGIC_SIZE: channel c occupies slice [c*LOGIC_SIZE +: LOGIC_SIZE].
- s_ch_tvalid, in, NUM_CH: per-channel valid.
- s_ch_tready, out, NUM_CH: per-channel ready; combinational, at most one bit high.
- o_to_encoder, out, 8: lane byte, registered.
- o_k_char, out, 1: 1 means o_to_encoder is a control character; registered.
- i_enc_ready, in, 1: encoder consumes the presented byte on this clock edge.
- o_active_ch, out, $clog2(NUM_CH): latched grant index.
- o_busy, out, 1: 1 whenever state is not IDLE.

Behaviour:
- Reset values: o_to_encoder=8'hBC, o_k_char=1, s_ch_tready=0, o_active_ch=0, o_busy=0, state=IDLE, rr_ptr=0, idle_cnt=0, word_cnt=0, byte strobe=0.
- The lane is always valid. A byte is consumed on an edge where i_enc_ready=1.
- When i_enc_ready=0, all state, outputs and counters hold, and s_ch_tready=0.
- The next byte appears one cycle after consumption, so continuous i_enc_ready gives 1 byte/clk.
- IDLE: drive 8'hBC with k=1 and count consumed commas in idle_cnt, saturating at IDLE_MIN. When idle_cnt reaches IDLE_MIN and any tvalid is high on a consume edge:
  - grant the first valid channel at or after rr_ptr, searching upward with wrap;
  - latch the grant into o_active_ch;
  - go to SOF.
- SOF: drive 8'hFB with k=1. On consume, go to CHID.
- CHID: drive the zero-extended grant index with k=0. On the consume edge, s_ch_tready[grant]=1:
  - if tvalid, load the word into the shift register, set word_cnt=1 and go to DATA;
  - otherwise go to EOF (zero-word frame is legal).
- DATA: drive byte[strobe] with k=0; strobe increments on consume. On consumption of the last byte (strobe = LOGIC_SIZE/8-1):
  - strobe wraps to 0;
  - if word_cnt<MAX_BURST, s_ch_tready[grant]=1 that cycle;
  - if the word is accepted, load it, increment word_cnt and stay in DATA;
  - otherwise go to EOF (or CRC when the optional feature is compiled in).
- EOF: drive 8'hFD with k=1. On consume: rr_ptr=(grant+1) mod NUM_CH, idle_cnt=0, word_cnt=0, go to IDLE.
- Simultaneous requests are resolved round-robin from rr_ptr. A channel is never granted twice in a row while another channel is valid at IDLE exit.
- Requests arriving during a frame wait; the grant is never pre-empted.
- Reset mid-frame: immediate return to reset values. The frame is truncated with no EOF, and the receiver resynchronises on commas.
- word_cnt is $clog2(MAX_BURST+1) bits wide. The strobe is $clog2(LOGIC_SIZE/8) bits wide, minimum 1.

Optional Feature:
- Macro: SERDES_TX_CRC8_EN.
- Defined: a CRC state is inserted between the last DATA byte and EOF.
  - It drives CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) computed over the CHID byte and all DATA bytes, with k=0.
  - A zero-word frame goes CHID to CRC to EOF.
- Undefined: there is no CRC state, no CRC logic, and DATA/CHID go directly to EOF.

Decomposition:
- Package serdes_pkg holds:
  - K28_5=8'hBC, K27_7=8'hFB, K29_7=8'hFD;
  - the tx_state_t enum (IDLE, SOF, CHID, DATA, CRC, EOF);
  - the crc8_byte function.
- One sub-module, rr_arbiter #(NUM_CH): combinational inputs req and ptr; outputs gnt_idx and any_req.

Test Plan:
- Reset with i_enc_ready=1 and no tvalid: lane shows BC/k=1 every cycle, o_busy=0.
- Ch2 presents 32'hDDCCBBAA, one word, after 2 commas: lane shows BC BC, FB(k), 02, AA BB CC DD, FD(k), then BC; tready[2] is high exactly once.
- Ch0 and ch3 valid simultaneously with rr_ptr=0: frames go ch0 then ch3, each separated by at least 2 commas, and rr_ptr=0 afterwards. Ch0 holds tvalid for 6 words, MAX_BURST=4: frame carries 4 words, then EOF; the next frame for ch0 carries the remaining 2 words.
- Toggle i_enc_ready 1,0,0,1 during DATA: byte holds unchanged across the stall with no skipped or duplicated byte.
- Assert reset mid-DATA: next cycle shows BC/k=1, tready=0, o_busy=0; re-arbitration starts after IDLE_MIN commas.
- With SERDES_TX_CRC8_EN, ch1 word 32'h00000000: the byte before FD equals crc8 over {01,00,00,00,00}, matching the bench model; without the macro, FD immediately follows the data.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared control characters, transmit FSM state type and the CRC-8 byte update
// used by the serdes transmit scheduler.
package serdes_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;

  typedef enum logic [2:0] {IDLE, SOF, CHID, DATA, CRC, EOF} tx_state_t;

  // CRC-8, poly 0x07, MSB-first, one byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above ptr,
// wrapping around.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx,
  output logic                      any_req
);

  localparam int unsigned IW = $clog2(NUM_CH);

  always_comb begin
    int unsigned idx;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(ptr) + i) % NUM_CH;
      if (!any_req && req[idx[IW-1:0]]) begin
        gnt_idx = idx[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serdes_tx_scheduler.sv
// Frames round-robin AXIS grants onto one byte lane for an 8b/10b encoder.
// Define SERDES_TX_CRC8_EN to append a CRC-8 byte before EOF.
module serdes_tx_scheduler
  import serdes_pkg::*;
#(
  parameter int unsigned LOGIC_SIZE = 32,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned IDLE_MIN   = 2
) (
  input  logic                         m_axis_aclk,
  input  logic                         m_axis_reset_n,
  input  logic [NUM_CH*LOGIC_SIZE-1:0] s_ch_tdata,
  input  logic [NUM_CH-1:0]            s_ch_tvalid,
  output logic [NUM_CH-1:0]            s_ch_tready,
  output logic [7:0]                   o_to_encoder,
  output logic                         o_k_char,
  input  logic                         i_enc_ready,
  output logic [$clog2(NUM_CH)-1:0]    o_active_ch,
  output logic                         o_busy
);

  localparam int unsigned BPW = LOGIC_SIZE / 8;
  localparam int unsigned SW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned WCW = $clog2(MAX_BURST + 1);
  localparam int unsigned ICW = $clog2(IDLE_MIN + 1);
  localparam int unsigned IW  = $clog2(NUM_CH);

`ifdef SERDES_TX_CRC8_EN
  localparam tx_state_t PostData = CRC;
`else
  localparam tx_state_t PostData = EOF;
`endif

  tx_state_t             state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d, rr_ptr_q, rr_ptr_d, arb_idx;
  logic                  arb_any;
  logic [ICW-1:0]        idle_cnt_q, idle_cnt_d, idle_inc;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic [LOGIC_SIZE-1:0] shreg_q, shreg_d, sel_word;
  logic                  sel_valid;
  logic [7:0]            byte_q, byte_d, cur_byte;
  logic                  k_q, k_d;
`ifdef SERDES_TX_CRC8_EN
  logic [7:0]            crc_q, crc_d;
`endif

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req    (s_ch_tvalid),
    .ptr    (rr_ptr_q),
    .gnt_idx(arb_idx),
    .any_req(arb_any)
  );

  assign sel_word  = s_ch_tdata[grant_q*LOGIC_SIZE +: LOGIC_SIZE];
  assign sel_valid = s_ch_tvalid[grant_q];
  assign cur_byte  = shreg_q[strb_q*8 +: 8];

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    idle_cnt_d  = idle_cnt_q;
    word_cnt_d  = word_cnt_q;
    strb_d      = strb_q;
    shreg_d     = shreg_q;
`ifdef SERDES_TX_CRC8_EN
    crc_d       = crc_q;
`endif
    s_ch_tready = '0;
    idle_inc    = (idle_cnt_q == ICW'(IDLE_MIN)) ? idle_cnt_q : idle_cnt_q + 1'b1;
    if (i_enc_ready) begin
      unique case (state_q)
        IDLE: begin
          idle_cnt_d = idle_inc;
          if (idle_inc == ICW'(IDLE_MIN) && arb_any) begin
            grant_d = arb_idx;
            state_d = SOF;
          end
        end
        SOF: state_d = CHID;
        CHID: begin
          s_ch_tready[grant_q] = 1'b1;
`ifdef SERDES_TX_CRC8_EN
          crc_d = crc8_byte(8'h00, 8'(grant_q));
`endif
          if (sel_valid) begin
            shreg_d    = sel_word;
            word_cnt_d = WCW'(1);
            strb_d     = '0;
            state_d    = DATA;
          end else begin
            state_d = PostData;
          end
        end
        DATA: begin
`ifdef SERDES_TX_CRC8_EN
          crc_d = crc8_byte(crc_q, cur_byte);
`endif
          if (strb_q == SW'(BPW - 1)) begin
            strb_d = '0;
            // Only ask for another word while the burst has room.
            if (word_cnt_q < WCW'(MAX_BURST)) begin
              s_ch_tready[grant_q] = 1'b1;
              if (sel_valid) begin
                shreg_d    = sel_word;
                word_cnt_d = word_cnt_q + 1'b1;
              end else begin
                state_d = PostData;
              end
            end else begin
              state_d = PostData;
            end
          end else begin
            strb_d = strb_q + 1'b1;
          end
        end
`ifdef SERDES_TX_CRC8_EN
        CRC: state_d = EOF;
`endif
        EOF: begin
          rr_ptr_d   = (grant_q == IW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
          idle_cnt_d = '0;
          word_cnt_d = '0;
          state_d    = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Lane byte is registered from next-state values so it changes right after consumption.
  always_comb begin
    byte_d = K28_5;
    k_d    = 1'b1;
    unique case (state_d)
      IDLE: ;
      SOF:  byte_d = K27_7;
      CHID: begin
        byte_d = 8'(grant_d);
        k_d    = 1'b0;
      end
      DATA: begin
        byte_d = shreg_d[strb_d*8 +: 8];
        k_d    = 1'b0;
      end
`ifdef SERDES_TX_CRC8_EN
      CRC: begin
        byte_d = crc_d;
        k_d    = 1'b0;
      end
`endif
      EOF:  byte_d = K29_7;
      default: ;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
    if (!m_axis_reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      word_cnt_q <= '0;
      strb_q     <= '0;
      shreg_q    <= '0;
      byte_q     <= K28_5;
      k_q        <= 1'b1;
`ifdef SERDES_TX_CRC8_EN
      crc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      word_cnt_q <= word_cnt_d;
      strb_q     <= strb_d;
      shreg_q    <= shreg_d;
      byte_q     <= byte_d;
      k_q        <= k_d;
`ifdef SERDES_TX_CRC8_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign o_to_encoder = byte_q;
  assign o_k_char     = k_q;
  assign o_active_ch  = grant_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Bench for serdes_tx_scheduler: directed phases plus random traffic checked
// against a frame-level model of the expected lane byte stream.
module tb_serdes_tx_scheduler;

  localparam int LS  = 32;
  localparam int NC  = 4;
  localparam int MB  = 4;
  localparam int IM  = 2;
  localparam int BPW = LS / 8;

  typedef struct packed {
    logic       k;
    logic [7:0] b;
    logic       rdy;
    logic       take;
  } elem_t;
  typedef logic [31:0] wq_t[$];

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC*LS-1:0]  tdata;
  logic [NC-1:0]     tvalid;
  logic [NC-1:0]     tready;
  logic [7:0]        lane;
  logic              k;
  logic              ready;
  logic [1:0]        act;
  logic              busy;

  always #5 clk = ~clk;

  serdes_tx_scheduler #(
    .LOGIC_SIZE(LS),
    .NUM_CH    (NC),
    .MAX_BURST (MB),
    .IDLE_MIN  (IM)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_reset_n(rst_n),
    .s_ch_tdata    (tdata),
    .s_ch_tvalid   (tvalid),
    .s_ch_tready   (tready),
    .o_to_encoder  (lane),
    .o_k_char      (k),
    .i_enc_ready   (ready),
    .o_active_ch   (act),
    .o_busy        (busy)
  );

  elem_t      fq[$];
  wq_t        chq[NC];
  int         m_idle, m_ptr, m_grant;
  int         grant_log[$], len_log[$];
  logic [7:0] cons_log[$];
  int         hs_cnt[NC];
  int         n_total, n_pass, n_fail;

  function automatic logic [7:0] crc_upd(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NC; c++) begin
      tvalid[c] = (chq[c].size() > 0);
      tdata[c*LS +: LS] = (chq[c].size() > 0) ? chq[c][0] : $urandom;
    end
  endtask

  // Whole frame is decided at grant: words queued now, capped at MB.
  task automatic build_frame(input int g);
    int n;
    logic [7:0] crc, bt;
    logic last;
    n = (chq[g].size() < MB) ? chq[g].size() : MB;
    fq.push_back({1'b1, 8'hFB, 1'b0, 1'b0});
    crc = crc_upd(8'h00, 8'(g));
    fq.push_back({1'b0, 8'(g), 1'b1, n > 0});
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < BPW; b++) begin
        bt   = chq[g][w][8*b +: 8];
        crc  = crc_upd(crc, bt);
        last = (b == BPW - 1);
        fq.push_back({1'b0, bt, last && (w + 1 < MB), last && (w + 1 < n)});
      end
    end
`ifdef SERDES_TX_CRC8_EN
    fq.push_back({1'b0, crc, 1'b0, 1'b0});
`endif
    fq.push_back({1'b1, 8'hFD, 1'b0, 1'b0});
    grant_log.push_back(g);
    len_log.push_back(n);
  endtask

  task automatic step(input logic rdy_in);
    logic [8:0]    exp_lane;
    logic [NC-1:0] exp_tr;
    logic          exp_busy;
    elem_t         e;
    int            c;
    @(negedge clk);
    ready = rdy_in;
    drive_inputs();
    #1;
    if (fq.size() == 0) begin
      exp_lane = {1'b1, 8'hBC};
      exp_tr   = '0;
      exp_busy = 1'b0;
    end else begin
      e        = fq[0];
      exp_lane = {e.k, e.b};
      exp_busy = 1'b1;
      exp_tr   = (ready && e.rdy) ? (NC'(1) << m_grant) : '0;
    end
    chk("lane", {k, lane}, exp_lane);
    chk("busy", busy, exp_busy);
    chk("tready", tready, exp_tr);
    if (exp_busy) chk("active_ch", act, m_grant);
    for (int i = 0; i < NC; i++) if (tready[i] && tvalid[i]) hs_cnt[i]++;
    if (ready) begin
      cons_log.push_back(lane);
      if (fq.size() == 0) begin
        m_idle = (m_idle < IM) ? m_idle + 1 : IM;
        if (m_idle == IM) begin
          for (int i = 0; i < NC; i++) begin
            c = (m_ptr + i) % NC;
            if (fq.size() == 0 && chq[c].size() > 0) begin
              m_grant = c;
              build_frame(c);
            end
          end
        end
      end else begin
        e = fq.pop_front();
        if (e.take) void'(chq[m_grant].pop_front());
        if (e.k && e.b == 8'hFD) begin
          m_ptr  = (m_grant + 1) % NC;
          m_idle = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ready = 1'b0;
    #1;
    chk("rst_lane", {k, lane}, 9'h1BC);
    chk("rst_tready", tready, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_active", act, 2'd0);
    fq.delete();
    m_idle  = 0;
    m_ptr   = 0;
    m_grant = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit all_idle();
    bit r;
    r = (fq.size() == 0);
    for (int c = 0; c < NC; c++) if (chq[c].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input int bound);
    for (int i = 0; i < bound && !all_idle(); i++) step(1'b1);
    chk("drain", all_idle(), 1'b1);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] expq[$]);
    chk({tag, "_len"}, cons_log.size() >= expq.size(), 1'b1);
    for (int i = 0; i < expq.size() && i < cons_log.size(); i++) chk(tag, cons_log[i], expq[i]);
  endtask

  initial begin
    logic [7:0] expq[$];
    logic [7:0] crc;
    int c;
    rst_n = 1'b0;
    ready = 1'b0;
    tvalid = '0;
    tdata = '0;
    n_total = 0;
    n_pass = 0;
    n_fail = 0;
    for (int i = 0; i < NC; i++) hs_cnt[i] = 0;
    do_reset();

    // Idle lane after reset
    repeat (6) step(1'b1);

    // Single word on ch2
    do_reset();
    cons_log.delete();
    for (int i = 0; i < NC; i++) hs_cnt[i] = 0;
    chq[2].push_back(32'hDDCCBBAA);
    repeat (12) step(1'b1);
    expq = {8'hBC, 8'hBC, 8'hFB, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef SERDES_TX_CRC8_EN
    crc = 8'h00;
    for (int i = 3; i < 8; i++) crc = crc_upd(crc, expq[i]);
    expq.push_back(crc);
`endif
    expq.push_back(8'hFD);
    expq.push_back(8'hBC);
    check_seq("seq_ch2", expq);
    chk("hs2_once", hs_cnt[2], 1);

    // Zero data word on ch1
    do_reset();
    cons_log.delete();
    chq[1].push_back(32'h00000000);
    repeat (12) step(1'b1);
    expq = {8'hBC, 8'hBC, 8'hFB, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SERDES_TX_CRC8_EN
    crc = 8'h00;
    for (int i = 3; i < 8; i++) crc = crc_upd(crc, expq[i]);
    expq.push_back(crc);
`endif
    expq.push_back(8'hFD);
    check_seq("seq_ch1", expq);

    // Round robin: ch0+ch3, then ch1+ch0 (pointer back at 0), then ch0 burst split
    do_reset();
    grant_log.delete();
    len_log.delete();
    chq[0].push_back(32'h10101010);
    chq[3].push_back(32'h30303030);
    drain(100);
    chk("rr_nframes_a", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("rr_first_a", grant_log[0], 0);
      chk("rr_second_a", grant_log[1], 3);
    end
    grant_log.delete();
    chq[1].push_back(32'h11111111);
    chq[0].push_back(32'h00000001);
    drain(100);
    chk("rr_nframes_b", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("rr_first_b", grant_log[0], 0);
      chk("rr_second_b", grant_log[1], 1);
    end
    grant_log.delete();
    len_log.delete();
    for (int i = 0; i < 6; i++) chq[0].push_back(32'hA0000000 + i);
    drain(200);
    chk("burst_nframes", len_log.size(), 2);
    if (len_log.size() == 2) begin
      chk("burst_len0", len_log[0], MB);
      chk("burst_len1", len_log[1], 2);
    end

    // Encoder stall mid-word
    do_reset();
    chq[1].push_back(32'h44332211);
    repeat (5) step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    drain(50);

    // Reset in the middle of DATA, then a fresh frame
    do_reset();
    chq[2].push_back(32'h87654321);
    repeat (6) step(1'b1);
    do_reset();
    chq[3].push_back(32'h5A5AA5A5);
    drain(50);

    // Random traffic with random encoder back-pressure
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) begin
        c = $urandom_range(0, NC - 1);
        if (!(fq.size() > 0 && m_grant == c)) chq[c].push_back($urandom);
      end
      step($urandom_range(0, 3) != 0);
    end
    drain(2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
